div_ctrl: RTL and testbench
===========================

DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 clk  in  1  system clock, all state on rising edge.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 ex_div_req_i  in  1  execute stage holds a valid DIV/DIVU/REM/REMU.
REQ-005 ex_op_code_i  in  3  divide opcode; ex_data1_i, ex_data2_i  in  32 each  operands; ex_rd_i  in  5  destination register.
REQ-006 flush_i  in  1  pipeline flush; kills the in-flight divide.
REQ-007 div_req_o  out  1  one-cycle issue pulse to the divider; div_op_code_o  out  3; div_data1_o, div_data2_o  out  32 each; div_reg_wr_addr_o  out  5.
REQ-008 div_busy_i, div_res_ready_i  in  1 each; div_res_i  in  32  divider status and result.
REQ-009 stall_o  out  1  hold the pipeline.
REQ-010 wb_en_o  out  1, wb_addr_o  out  5, wb_data_o  out  32  register-file write port.

Function
REQ-011 State machine states: IDLE, WAIT, DRAIN, DONE; all outputs except stall_o SHALL be registered.
REQ-012 IDLE with ex_div_req_i=1, flush_i=0, div_busy_i=0: capture opcode, operands and rd into div_*_o; pulse div_req_o for exactly one cycle; go to WAIT.
REQ-013 IDLE with ex_div_req_i=1 and div_busy_i=1: no issue, remain in IDLE.
REQ-014 WAIT with div_res_ready_i=1 and flush_i=0: wb_addr_o <= captured rd, wb_data_o <= div_res_i, wb_en_o <= 1 unless rd=0; go to DONE.
REQ-015 WAIT with flush_i=1: go to DRAIN; if div_res_ready_i=1 in the same cycle, discard the result and go to IDLE (flush wins).
REQ-016 DRAIN: divider runs to completion; on div_res_ready_i=1, discard the result (wb_en_o stays 0) and go to IDLE.
REQ-017 DONE: wb_en_o high for this one cycle only; go to IDLE unconditionally; flush_i in DONE does not cancel writeback.
REQ-018 stall_o = (IDLE and ex_div_req_i and not flush_i) or WAIT or (DRAIN and ex_div_req_i); stall_o=0 in DONE so the completed instruction leaves execute without reissue.
REQ-019 div_req_o SHALL never assert outside IDLE->WAIT; at most one divide outstanding.
REQ-020 Latency: result written one cycle after div_res_ready_i; no further dependence on divider cycle count.

Reset
REQ-021 With rst=1 at a clock edge: state IDLE; div_req_o, wb_en_o=0; div_op_code_o, div_data1_o, div_data2_o, div_reg_wr_addr_o, wb_addr_o, wb_data_o = 0; cache valid cleared.
REQ-022 Reset mid-operation SHALL abandon the in-flight divide with no writeback; any later div_res_ready_i while IDLE is ignored.

Configuration
REQ-023 Macro DIV_RES_CACHE_EN: when defined, the block keeps one entry {valid, opcode, data1, data2, result}, updated on each WAIT->DONE transition (not on discarded results).
REQ-024 With DIV_RES_CACHE_EN, an IDLE request matching the valid entry SHALL skip div_req_o and go directly to DONE with the cached result (one-cycle stall).
REQ-025 Without DIV_RES_CACHE_EN, no cache storage exists and every request issues to the divider.

Verification
REQ-026 DIVU 100/7, rd=5 -> one div_req_o pulse, stall until ready, one wb_en_o with wb_addr_o=5, wb_data_o=14.
REQ-027 DIV 0x80000000/0xFFFFFFFF rd=0 -> divide issued, stall released, wb_en_o never asserts.
REQ-028 flush_i 10 cycles after issue -> DRAIN, stall_o drops, divider result discarded, no wb_en_o; next request issues only after div_busy_i=0.
REQ-029 div_res_ready_i and flush_i in same WAIT cycle -> no writeback, state IDLE next cycle.
REQ-030 rst pulse in WAIT -> all outputs zero next cycle, late div_res_ready_i produces no writeback.
REQ-031 DIV_RES_CACHE_EN: REM -7/2 twice back-to-back -> second request no div_req_o, wb_data_o=0xFFFFFFFF two cycles after request.

Source files
------------

// File: rtl/div_ctrl.sv
// div_ctrl: issue/writeback controller sitting between the execute stage and
// an iterative divider. Holds the pipeline while a divide is outstanding,
// drains killed divides and writes the result back one cycle after ready.
// Optional single-entry result cache: define DIV_RES_CACHE_EN to enable it.
//
// state | meaning
// IDLE  | no divide outstanding, waiting for an execute-stage request
// WAIT  | divide issued, waiting for the divider result
// DRAIN | divide killed by flush, letting the divider finish, result dropped
// DONE  | writeback cycle, instruction leaves execute
module div_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_div_req_i,
  input  logic [2:0]  ex_op_code_i,
  input  logic [31:0] ex_data1_i,
  input  logic [31:0] ex_data2_i,
  input  logic [4:0]  ex_rd_i,
  input  logic        flush_i,
  output logic        div_req_o,
  output logic [2:0]  div_op_code_o,
  output logic [31:0] div_data1_o,
  output logic [31:0] div_data2_o,
  output logic [4:0]  div_reg_wr_addr_o,
  input  logic        div_busy_i,
  input  logic        div_res_ready_i,
  input  logic [31:0] div_res_i,
  output logic        stall_o,
  output logic        wb_en_o,
  output logic [4:0]  wb_addr_o,
  output logic [31:0] wb_data_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e      state_q;
  logic        div_req_q;
  logic [2:0]  op_q;
  logic [31:0] data1_q;
  logic [31:0] data2_q;
  logic [4:0]  rd_q;
  logic        wb_en_q;
  logic [4:0]  wb_addr_q;
  logic [31:0] wb_data_q;

  logic        cache_hit;
  logic [31:0] cache_res;
  logic        res_accept;

  // a result is committed only when it arrives in WAIT without a flush
  assign res_accept = (state_q == S_WAIT) && div_res_ready_i && !flush_i;

`ifdef DIV_RES_CACHE_EN
  logic        cache_vld_q;
  logic [2:0]  cache_op_q;
  logic [31:0] cache_d1_q;
  logic [31:0] cache_d2_q;
  logic [31:0] cache_res_q;

  assign cache_hit = cache_vld_q && (cache_op_q == ex_op_code_i) &&
                     (cache_d1_q == ex_data1_i) && (cache_d2_q == ex_data2_i);
  assign cache_res = cache_res_q;

  // remember the last committed divide; discarded results never enter
  always_ff @(posedge clk) begin
    if (rst) begin
      cache_vld_q <= 1'b0;
      cache_op_q  <= '0;
      cache_d1_q  <= '0;
      cache_d2_q  <= '0;
      cache_res_q <= '0;
    end else if (res_accept) begin
      cache_vld_q <= 1'b1;
      cache_op_q  <= op_q;
      cache_d1_q  <= data1_q;
      cache_d2_q  <= data2_q;
      cache_res_q <= div_res_i;
    end
  end
`else
  assign cache_hit = 1'b0;
  assign cache_res = '0;
`endif

  // sequencing FSM with registered issue and writeback outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      div_req_q <= 1'b0;
      op_q      <= '0;
      data1_q   <= '0;
      data2_q   <= '0;
      rd_q      <= '0;
      wb_en_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else begin
      div_req_q <= 1'b0;
      wb_en_q   <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (ex_div_req_i && !flush_i) begin
            if (cache_hit) begin
              wb_addr_q <= ex_rd_i;
              wb_data_q <= cache_res;
              wb_en_q   <= (ex_rd_i != 5'd0);
              state_q   <= S_DONE;
            end else if (!div_busy_i) begin
              op_q      <= ex_op_code_i;
              data1_q   <= ex_data1_i;
              data2_q   <= ex_data2_i;
              rd_q      <= ex_rd_i;
              div_req_q <= 1'b1;
              state_q   <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (flush_i) begin
            // a result arriving with the flush is simply dropped
            state_q <= div_res_ready_i ? S_IDLE : S_DRAIN;
          end else if (div_res_ready_i) begin
            wb_addr_q <= rd_q;
            wb_data_q <= div_res_i;
            wb_en_q   <= (rd_q != 5'd0);
            state_q   <= S_DONE;
          end
        end
        S_DRAIN: begin
          if (div_res_ready_i) state_q <= S_IDLE;
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // stall is combinational so a new request is held in the same cycle
  assign stall_o = ((state_q == S_IDLE) && ex_div_req_i && !flush_i) ||
                   (state_q == S_WAIT) ||
                   ((state_q == S_DRAIN) && ex_div_req_i);

  assign div_req_o         = div_req_q;
  assign div_op_code_o     = op_q;
  assign div_data1_o       = data1_q;
  assign div_data2_o       = data2_q;
  assign div_reg_wr_addr_o = rd_q;
  assign wb_en_o           = wb_en_q;
  assign wb_addr_o         = wb_addr_q;
  assign wb_data_o         = wb_data_q;

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: randomized scoreboard bench for div_ctrl with a behavioural
// divider and a RISC-V divide reference model.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_div_req_i = 1'b0;
  logic [2:0]  ex_op_code_i = '0;
  logic [31:0] ex_data1_i = '0;
  logic [31:0] ex_data2_i = '0;
  logic [4:0]  ex_rd_i = '0;
  logic        flush_i = 1'b0;
  logic        div_req_o;
  logic [2:0]  div_op_code_o;
  logic [31:0] div_data1_o;
  logic [31:0] div_data2_o;
  logic [4:0]  div_reg_wr_addr_o;
  logic        div_busy_i = 1'b0;
  logic        div_res_ready_i = 1'b0;
  logic [31:0] div_res_i = '0;
  logic        stall_o;
  logic        wb_en_o;
  logic [4:0]  wb_addr_o;
  logic [31:0] wb_data_o;

  always #5 clk = ~clk;

  div_ctrl dut (
    .clk(clk), .rst(rst),
    .ex_div_req_i(ex_div_req_i), .ex_op_code_i(ex_op_code_i),
    .ex_data1_i(ex_data1_i), .ex_data2_i(ex_data2_i), .ex_rd_i(ex_rd_i),
    .flush_i(flush_i),
    .div_req_o(div_req_o), .div_op_code_o(div_op_code_o),
    .div_data1_o(div_data1_o), .div_data2_o(div_data2_o),
    .div_reg_wr_addr_o(div_reg_wr_addr_o),
    .div_busy_i(div_busy_i), .div_res_ready_i(div_res_ready_i), .div_res_i(div_res_i),
    .stall_o(stall_o),
    .wb_en_o(wb_en_o), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o)
  );

  int total = 0;
  int bad = 0;

  typedef struct { logic [4:0] addr; logic [31:0] data; } wb_t;
  wb_t exp_q[$];

  int issues = 0;
  int lat_force = -1;

  // reference cache entry (only consulted when the cache is built in)
  bit          m_vld = 1'b0;
  logic [2:0]  m_op;
  logic [31:0] m_a, m_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // RISC-V M-extension divide semantics (4=DIV 5=DIVU 6=REM 7=REMU)
  function automatic logic [31:0] ref_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    bit ovf;
    sa = a; sb = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd4:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
      3'd5:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6:    return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit model_hit(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_RES_CACHE_EN
    return m_vld && (m_op == op) && (m_a == a) && (m_b == b);
`else
    return 1'b0;
`endif
  endfunction

  // behavioural divider: random latency, busy one cycle beyond the ready pulse
  initial begin
    int dstate = 0;
    int cnt = 0;
    logic [31:0] res = '0;
    forever begin
      @(negedge clk);
      if (div_req_o) check("issue_while_divider_idle", 32'(dstate == 0), 32'd1);
      div_res_i = $urandom;
      case (dstate)
        0: if (div_req_o) begin
             issues++;
             res = ref_div(div_op_code_o, div_data1_o, div_data2_o);
             cnt = (lat_force >= 0) ? lat_force : int'($urandom_range(1, 12));
             div_busy_i = 1'b1;
             dstate = 1;
           end
        1: if (cnt == 0) begin
             div_res_ready_i = 1'b1;
             div_res_i = res;
             dstate = 2;
           end else cnt--;
        2: begin div_res_ready_i = 1'b0; dstate = 3; end
        default: begin div_busy_i = 1'b0; dstate = 0; end
      endcase
    end
  end

  // writeback monitor: every wb_en_o pulse must match the oldest expectation
  initial begin
    wb_t e;
    forever begin
      @(negedge clk);
      if (wb_en_o) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_wb: got addr %0d data %0h expected no writeback at %0t", wb_addr_o, wb_data_o, $time);
        end else begin
          e = exp_q.pop_front();
          check("wb_addr", 32'(wb_addr_o), 32'(e.addr));
          check("wb_data", wb_data_o, e.data);
        end
      end
    end
  end

  // present one divide and hold it until the pipeline releases it; called at a negedge
  task automatic run_instr(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd, output int stalls);
    int iss0;
    bit hit, done;
    hit = model_hit(op, a, b);
    if (rd != 0) exp_q.push_back('{rd, ref_div(op, a, b)});
    m_vld = 1'b1; m_op = op; m_a = a; m_b = b;
    iss0 = issues;
    ex_div_req_i = 1'b1; ex_op_code_i = op; ex_data1_i = a; ex_data2_i = b; ex_rd_i = rd;
    stalls = 0; done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      #1;
      if (!stall_o) done = 1'b1;
      else begin stalls++; @(negedge clk); end
    end
    check("retire_before_timeout", 32'(done), 32'd1);
    @(negedge clk);
    ex_div_req_i = 1'b0;
    check("issue_count", 32'(issues - iss0), hit ? 32'd0 : 32'd1);
  endtask

  // wait (bounded) until the divider has accepted an issue
  task automatic wait_issue(input int iss0);
    bit seen = 1'b0;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge clk); #1;
      if (issues != iss0) seen = 1'b1;
    end
    check("issue_seen", 32'(seen), 32'd1);
  endtask

  // issue a long divide, kill it k cycles later, check DRAIN stall behaviour
  task automatic run_flush(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd, input int k);
    int iss0;
    iss0 = issues;
    lat_force = 40;
    ex_div_req_i = 1'b1; ex_op_code_i = op; ex_data1_i = a; ex_data2_i = b; ex_rd_i = rd;
    wait_issue(iss0);
    lat_force = -1;
    repeat (k) @(negedge clk);
    flush_i = 1'b1; ex_div_req_i = 1'b0;
    @(negedge clk);
    flush_i = 1'b0;
    #1 check("drain_stall_no_req", 32'(stall_o), 32'd0);
    ex_div_req_i = 1'b1;
    #1 check("drain_stall_req", 32'(stall_o), 32'd1);
    ex_div_req_i = 1'b0;
  endtask

  // flush lands in the very cycle the result is ready
  task automatic run_flush_ready(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] rd);
    int iss0;
    bit seen = 1'b0;
    iss0 = issues;
    ex_div_req_i = 1'b1; ex_op_code_i = op; ex_data1_i = a; ex_data2_i = b; ex_rd_i = rd;
    wait_issue(iss0);
    for (int c = 0; c < 60 && !seen; c++) begin
      if (div_res_ready_i) seen = 1'b1;
      else begin @(negedge clk); #1; end
    end
    check("ready_seen", 32'(seen), 32'd1);
    flush_i = 1'b1; ex_div_req_i = 1'b0;
    @(negedge clk);
    flush_i = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_div_req"}, 32'(div_req_o), 32'd0);
    check({tag, "_wb_en"}, 32'(wb_en_o), 32'd0);
    check({tag, "_op"}, 32'(div_op_code_o), 32'd0);
    check({tag, "_d1"}, div_data1_o, 32'd0);
    check({tag, "_d2"}, div_data2_o, 32'd0);
    check({tag, "_rd"}, 32'(div_reg_wr_addr_o), 32'd0);
    check({tag, "_wb_addr"}, 32'(wb_addr_o), 32'd0);
    check({tag, "_wb_data"}, wb_data_o, 32'd0);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3, 4:    return 32'($urandom_range(0, 50));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int st, st2, kind;
    logic [2:0] op;
    logic [31:0] a, b;
    logic [4:0] rd;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    check("reset_stall", 32'(stall_o), 32'd0);
    rst = 1'b0;

    run_instr(3'd5, 32'd100, 32'd7, 5'd5, st);
    run_instr(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, st);

    run_flush(3'd5, 32'd1234, 32'd3, 5'd9, 10);
    run_instr(3'd7, 32'd1000, 32'd33, 5'd10, st);

    run_flush_ready(3'd4, 32'd77, 32'd5, 5'd11);
    run_instr(3'd6, 32'd77, 32'd5, 5'd12, st);

    lat_force = 40;
    ex_div_req_i = 1'b1; ex_op_code_i = 3'd5; ex_data1_i = 32'd999; ex_data2_i = 32'd4; ex_rd_i = 5'd13;
    st = issues;
    wait_issue(st);
    lat_force = -1;
    repeat (3) @(negedge clk);
    rst = 1'b1; ex_div_req_i = 1'b0;
    m_vld = 1'b0;
    @(negedge clk);
    #1 check_all_zero("midreset");
    rst = 1'b0;
    run_instr(3'd5, 32'd50, 32'd5, 5'd14, st);

    run_instr(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd3, st);
    run_instr(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd3, st2);
`ifdef DIV_RES_CACHE_EN
    check("cache_hit_stall_cycles", 32'(st2), 32'd1);
`endif

    op = 3'd4; a = 32'd1; b = 32'd1;
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        op = 3'($urandom_range(4, 7));
        a = rand_operand();
        b = rand_operand();
      end
      rd = 5'($urandom_range(0, 31));
      kind = $urandom_range(0, 9);
      if (kind == 0 && !model_hit(op, a, b))
        run_flush(op, a, b, rd, $urandom_range(1, 15));
      else if (kind == 1 && !model_hit(op, a, b))
        run_flush_ready(op, a, b, rd);
      else begin
        if (kind == 2) repeat ($urandom_range(1, 3)) @(negedge clk);
        run_instr(op, a, b, rd, st);
      end
    end

    repeat (60) @(negedge clk);
    check("pending_writebacks", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
